// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared constants and state encodings for the I2C bus arbiter.
package i2c_bus_arbiter_pkg;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // 100 ms at 38 MHz
  localparam logic [23:0] DEFAULT_TIMEOUT_CYCLES = 24'd3_800_000;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_DRAIN   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester/arbiter handshake bundle. The arbiter uses the slave modport,
// the requester side and master-status driver use the master modport.
interface i2c_bus_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic               master_busy;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_id;
  logic               bus_idle;
  logic               master_abort;
  logic               timeout_err;

  modport master (
    output req, rel, master_busy,
    input  grant, grant_id, bus_idle, master_abort, timeout_err
  );

  modport slave (
    input  req, rel, master_busy,
    output grant, grant_id, bus_idle, master_abort, timeout_err
  );
endinterface

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above rr_ptr,
// wrapping around to bit 0.
module i2c_bus_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [ID_W-1:0]    win_idx,
  output logic               any
);

  always_comb begin
    int j;
    winner  = '0;
    win_idx = '0;
    any     = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any && req[j]) begin
        winner[j] = 1'b1;
        win_idx   = ID_W'(j);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbitration for the shared EFB I2C master. Ownership is
// held for a whole transaction and handed over only once the master is idle.
// Optional watchdog enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter
  import i2c_bus_arbiter_pkg::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          ID_W           = 3,
  parameter logic [23:0] TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              sys_clk,
  input  logic              resetn,
  i2c_bus_arbiter_if.slave  bus
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (2 ** ID_W) < NUM_REQ || TIMEOUT_CYCLES == 24'd0) begin : g_bad_cfg
    $error("i2c_bus_arbiter: unsupported parameter combination");
  end

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] pick_winner;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               owner_end;

  i2c_bus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req     (bus.req),
    .rr_ptr  (rr_ptr),
    .winner  (pick_winner),
    .win_idx (pick_idx),
    .any     (pick_any)
  );

  // Only the owner's own rel/req can end ownership; others stay pending.
  assign owner_end = (|(bus.rel & bus.grant)) || !(|(bus.req & bus.grant));

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(int'(TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 24'd1);
  localparam logic [CNT_W-1:0] WD_MAX  = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] wd_cnt;
`else
  assign bus.master_abort = LOW;
  assign bus.timeout_err  = LOW;
`endif

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      bus.grant    <= '0;
      bus.grant_id <= '0;
      bus.bus_idle <= HIGH;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_cnt           <= '0;
      bus.master_abort <= LOW;
      bus.timeout_err  <= LOW;
`endif
    end else begin
`ifdef I2C_ARB_TIMEOUT_EN
      bus.master_abort <= LOW;
      bus.timeout_err  <= LOW;
`endif
      case (state)
        ARB_IDLE: begin
          if (pick_any) begin
            state        <= ARB_GRANTED;
            bus.grant    <= pick_winner;
            bus.grant_id <= pick_idx;
            bus.bus_idle <= LOW;
            rr_ptr       <= (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt       <= '0;
`endif
          end
        end
        ARB_GRANTED: begin
          if (owner_end) state <= ARB_DRAIN;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt <= wd_cnt + CNT_W'(1);
          // A release landing on the limit cycle needs no abort.
          if (wd_cnt == WD_LAST && !owner_end) begin
            bus.master_abort <= HIGH;
            bus.timeout_err  <= HIGH;
            state            <= ARB_DRAIN;
          end
`endif
        end
        ARB_DRAIN: begin
`ifdef I2C_ARB_TIMEOUT_EN
          if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + CNT_W'(1);
`endif
          if (!bus.master_busy) begin
            state        <= ARB_IDLE;
            bus.grant    <= '0;
            bus.grant_id <= '0;
            bus.bus_idle <= HIGH;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: reset, single requester, fairness,
// drain hold, spurious release and watchdog (I2C_ARB_TIMEOUT_EN aware).
module tb_i2c_bus_arbiter;

  logic sys_clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  int   overlap  = 0;

  always #5 sys_clk = ~sys_clk;

  i2c_bus_arbiter_if #(.NUM_REQ(2), .ID_W(3)) bus ();

  i2c_bus_arbiter #(.NUM_REQ(2), .ID_W(3), .TIMEOUT_CYCLES(24'd100)) dut (
    .sys_clk (sys_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always @(negedge sys_clk)
    if (resetn && bus.bus_idle && (bus.grant != 2'b00)) overlap++;

  task automatic step(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_g;
    int abort_cnt, terr_cnt, abort_at;
    logic [1:0] grant_at_101;

    resetn = 1'b0;
    bus.req = 2'b00;
    bus.rel = 2'b00;
    bus.master_busy = 1'b0;
    step(3);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_id", 32'(bus.grant_id), 32'd0);
    check("rst_idle", 32'(bus.bus_idle), 32'd1);
    check("rst_abort", 32'(bus.master_abort), 32'd0);
    check("rst_terr", 32'(bus.timeout_err), 32'd0);
    resetn = 1'b1;
    step(1);

    // Grant, then asynchronous reset mid-grant
    bus.req = 2'b11;
    step(1);
    check("pre_rst_grant", 32'(bus.grant), 32'h1);
    resetn = 1'b0;
    #2;
    check("async_grant", 32'(bus.grant), 32'd0);
    check("async_idle", 32'(bus.bus_idle), 32'd1);
    check("async_id", 32'(bus.grant_id), 32'd0);
    #8;
    resetn = 1'b1;
    step(1);
    check("post_rst_first", 32'(bus.grant), 32'h1);
    bus.req = 2'b00;
    step(1);
    check("drop_drain_grant", 32'(bus.grant), 32'h1);
    step(1);
    check("drop_idle_grant", 32'(bus.grant), 32'd0);
    check("drop_idle", 32'(bus.bus_idle), 32'd1);

    // Single requester 1, release with master idle -> low at n+2
    step(2);
    bus.req = 2'b10;
    step(1);
    check("single_grant", 32'(bus.grant), 32'h2);
    check("single_id", 32'(bus.grant_id), 32'd1);
    check("single_idle", 32'(bus.bus_idle), 32'd0);
    step(13);
    check("single_hold", 32'(bus.grant), 32'h2);
    bus.rel = 2'b10;
    bus.req = 2'b00;
    step(1);
    bus.rel = 2'b00;
    check("single_n1", 32'(bus.grant), 32'h2);
    step(1);
    check("single_n2", 32'(bus.grant), 32'd0);
    check("single_n2_idle", 32'(bus.bus_idle), 32'd1);

    // Contention: rr_ptr is back at 0, grants must alternate 01,10,01,10
    bus.req = 2'b11;
    step(1);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_grant%0d", k), 32'(bus.grant), 32'(exp_g));
      step(9);
      bus.rel = exp_g;
      step(1);
      bus.rel = 2'b00;
      check($sformatf("rr_drain%0d", k), 32'(bus.grant), 32'(exp_g));
      step(1);
      check($sformatf("rr_gap%0d", k), 32'(bus.grant), 32'd0);
      check($sformatf("rr_gap_idle%0d", k), 32'(bus.bus_idle), 32'd1);
      step(1);
    end
    check("rr_next", 32'(bus.grant), 32'h1);

    // Spurious release from non-owner
    bus.rel = 2'b10;
    step(1);
    bus.rel = 2'b00;
    check("spur_grant", 32'(bus.grant), 32'h1);
    check("spur_id", 32'(bus.grant_id), 32'd0);
    step(3);
    check("spur_hold", 32'(bus.grant), 32'h1);

    // Drain hold with master busy for 50 cycles
    bus.master_busy = 1'b1;
    bus.rel = 2'b01;
    step(1);
    bus.rel = 2'b00;
    step(49);
    check("drain_hold", 32'(bus.grant), 32'h1);
    check("drain_idle", 32'(bus.bus_idle), 32'd0);
    bus.master_busy = 1'b0;
    step(1);
    check("drain_drop", 32'(bus.grant), 32'd0);
    step(1);
    check("drain_next", 32'(bus.grant), 32'h2);
    check("drain_next_id", 32'(bus.grant_id), 32'd1);

    // Owner 1 never releases
    abort_cnt = 0;
    terr_cnt = 0;
    abort_at = -1;
    grant_at_101 = 2'bxx;
    for (int c = 1; c <= 150; c++) begin
      step(1);
      if (bus.master_abort === 1'b1) begin
        abort_cnt++;
        abort_at = c;
      end
      if (bus.timeout_err === 1'b1) terr_cnt++;
      if (c == 101) grant_at_101 = bus.grant;
    end
`ifdef I2C_ARB_TIMEOUT_EN
    check("wd_abort_cnt", 32'(abort_cnt), 32'd1);
    check("wd_terr_cnt", 32'(terr_cnt), 32'd1);
    check("wd_abort_at", 32'(abort_at), 32'd100);
    check("wd_drop", 32'(grant_at_101), 32'd0);
`else
    check("wd_abort_cnt", 32'(abort_cnt), 32'd0);
    check("wd_terr_cnt", 32'(terr_cnt), 32'd0);
    check("wd_hold101", 32'(grant_at_101), 32'h2);
    check("wd_hold_end", 32'(bus.grant), 32'h2);
`endif

    bus.req = 2'b00;
    step(4);
    check("end_idle", 32'(bus.bus_idle), 32'd1);
    check("idle_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
